// File: rtl/tx_pkg.sv
// ============================================================================
//  Module : tx_pkg
//  Brief  : Shared FSM state type and packet-width helper for the transmitter.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tx_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARB      = 2'd1,
    SEND     = 2'd2,
    WAIT_ACK = 2'd3
  } tx_state_e;

  function automatic int pkt_w(input int id, input int addr, input int data);
    return id + addr + data;
  endfunction

endpackage

`default_nettype wire

// File: rtl/transmitter_if.sv
// ============================================================================
//  Module : transmitter_if
//  Brief  : Core write port plus photonic-channel req/grant/ack bundle.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface transmitter_if
  import tx_pkg::*;
#(
  parameter int ID_W   = 2,
  parameter int ADDR_W = 2,
  parameter int DATA_W = 2
) ();

  localparam int PKT_W = pkt_w(ID_W, ADDR_W, DATA_W);

  logic              wr_en;
  logic [ID_W-1:0]   wr_dest;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic              tx_req;
  logic              tx_grant;
  logic [PKT_W-1:0]  tx_out;
  logic              tx_valid;
  logic              tx_ack;
  logic              ovf_err;
  logic              drop_err;

  modport master (
    input  wr_en, wr_dest, wr_addr, wr_data, tx_grant, tx_ack,
    output full, tx_req, tx_out, tx_valid, ovf_err, drop_err
  );

  modport slave (
    output wr_en, wr_dest, wr_addr, wr_data, tx_grant, tx_ack,
    input  full, tx_req, tx_out, tx_valid, ovf_err, drop_err
  );

endinterface

`default_nettype wire

// File: rtl/tx_fifo.sv
// ============================================================================
//  Module : tx_fifo
//  Brief  : Packet FIFO with wrapping pointers and occupancy count; head is
//           presented combinationally on dout.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tx_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   push,
  input  wire logic                   pop,
  input  wire logic [WIDTH-1:0]       din,
  output      logic [WIDTH-1:0]       dout,
  output      logic                   full,
  output      logic                   empty,
  output      logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == (PTR_W + 1)'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

`default_nettype wire

// File: rtl/transmitter.sv
// ============================================================================
//  Module : transmitter
//  Brief  : Source end of the node-to-node packet link: FIFO-buffered core
//           writes, req/grant arbitration, one packet per grant.
//           Optional ack/retry/drop handling when TX_ACK_EN is defined.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module transmitter
  import tx_pkg::*;
#(
  parameter int ID_W        = 2,
  parameter int ADDR_W      = 2,
  parameter int DATA_W      = 2,
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 8,
  parameter int MAX_RETRY   = 3
) (
  input wire logic      clk,
  input wire logic      rst,
  transmitter_if.master bus
);

  localparam int PKT_W = pkt_w(ID_W, ADDR_W, DATA_W);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  tx_state_e        state;
  logic             push;
  logic             pop;
  logic             more;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] count;
  logic [PKT_W-1:0] head;
  logic [PKT_W-1:0] tx_out_q;
  logic             tx_req_q;
  logic             tx_valid_q;
  logic             ovf_q;

  // full is judged before any same-cycle pop, so a write into a full FIFO is lost
  assign push = bus.wr_en && !fifo_full;
  // entries left once the head leaves, counting a write landing this cycle
  assign more = (count > CNT_W'(1)) || push;

  tx_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({bus.wr_data, bus.wr_addr, bus.wr_dest}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

`ifdef TX_ACK_EN
  localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic [TMR_W-1:0] timer;
  logic [RTY_W-1:0] retry;
  logic             drop_q;
  logic             timeout;
  logic             give_up;

  assign timeout = (timer == TMR_W'(ACK_TIMEOUT - 1));
  assign give_up = timeout && (retry == RTY_W'(MAX_RETRY));
  assign pop     = (state == WAIT_ACK) && (bus.tx_ack || give_up);
  assign bus.drop_err = drop_q;
`else
  localparam int unused_cfg = ACK_TIMEOUT + MAX_RETRY;
  logic unused_ack;

  assign unused_ack   = bus.tx_ack;
  assign pop          = (state == SEND);
  assign bus.drop_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      tx_req_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_out_q   <= '0;
      ovf_q      <= 1'b0;
`ifdef TX_ACK_EN
      timer      <= '0;
      retry      <= '0;
      drop_q     <= 1'b0;
`endif
    end else begin
      tx_valid_q <= 1'b0;
      tx_out_q   <= '0;
      if (bus.wr_en && fifo_full) ovf_q <= 1'b1;

      case (state)
        IDLE: begin
          if (!fifo_empty || push) begin
            state    <= ARB;
            tx_req_q <= 1'b1;
          end
        end

        ARB: begin
          if (bus.tx_grant) begin
            state      <= SEND;
            tx_req_q   <= 1'b0;
            tx_valid_q <= 1'b1;
            tx_out_q   <= head;
          end
        end

        SEND: begin
`ifdef TX_ACK_EN
          state <= WAIT_ACK;
          timer <= '0;
`else
          if (more) begin
            state    <= ARB;
            tx_req_q <= 1'b1;
          end else begin
            state <= IDLE;
          end
`endif
        end

`ifdef TX_ACK_EN
        WAIT_ACK: begin
          if (bus.tx_ack || give_up) begin
            retry <= '0;
            if (!bus.tx_ack) drop_q <= 1'b1;
            if (more) begin
              state    <= ARB;
              tx_req_q <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (timeout) begin
            // head stays queued and is offered again on the next grant
            retry    <= retry + 1'b1;
            state    <= ARB;
            tx_req_q <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
`endif

        default: begin
          state    <= IDLE;
          tx_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.full     = fifo_full;
  assign bus.tx_req   = tx_req_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_out   = tx_out_q;
  assign bus.ovf_err  = ovf_q;

endmodule

`default_nettype wire
